// File: rtl/pa_core_pkg.sv
// pa_core_pkg: shared types, opcodes and line helpers
// for the pa_core multicycle core.
package pa_core_pkg;

   localparam int LINE_W = 128;
   localparam int XLEN   = 32;

   localparam logic [6:0] OP_ADD  = 7'h00;
   localparam logic [6:0] OP_SUB  = 7'h01;
   localparam logic [6:0] OP_MUL  = 7'h02;
   localparam logic [6:0] OP_ADDI = 7'h05;
   localparam logic [6:0] OP_LDW  = 7'h11;
   localparam logic [6:0] OP_STW  = 7'h13;
   localparam logic [6:0] OP_BEQ  = 7'h30;
   localparam logic [6:0] OP_JUMP = 7'h31;
   localparam logic [6:0] OP_NOP  = 7'h7F;

   typedef struct packed {
      logic [31:0]       addr;
      logic              is_store;
      logic [LINE_W-1:0] data;
   } memory_request_t;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_IWAIT,
      ST_EXEC,
      ST_DWAIT,
      ST_SWAIT,
      ST_HALT
   } state_e;

   function automatic logic [XLEN-1:0] sext15(
      input logic [14:0] v
   );
      return {{17{v[14]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] get_word(
      input logic [LINE_W-1:0] line,
      input logic [1:0]        idx
   );
      return line[{idx, 5'd0} +: 32];
   endfunction

   function automatic logic [LINE_W-1:0] put_word(
      input logic [LINE_W-1:0] line,
      input logic [1:0]        idx,
      input logic [XLEN-1:0]   w
   );
      logic [LINE_W-1:0] r;
      r = line;
      r[{idx, 5'd0} +: 32] = w;
      return r;
   endfunction

endpackage

// File: rtl/pa_core_alu.sv
// pa_core_alu: combinational arithmetic, effective-address
// add and branch-equality compare.
module pa_core_alu
   import pa_core_pkg::*;
(
   input  logic [6:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic [XLEN-1:0] i_imm,
   output logic [XLEN-1:0] o_res,
   output logic            o_eq
);

   logic w_use_imm;

   // loads and stores reuse the ADDI adder for their address
   assign w_use_imm = (i_op == OP_ADDI) ||
                      (i_op == OP_LDW)  ||
                      (i_op == OP_STW);

   assign o_eq = (i_a == i_b);

   always_comb begin
      o_res = i_a + i_b;
      unique case (1'b1)
         w_use_imm:        o_res = i_a + i_imm;
         (i_op == OP_SUB): o_res = i_a - i_b;
         (i_op == OP_MUL): o_res = i_a * i_b;
         default:          o_res = i_a + i_b;
      endcase
   end

endmodule

// File: rtl/pa_core_top.sv
// pa_core_top: multicycle core with one-line I/D buffers and
// a single outstanding line request on the miss ports.
module pa_core_top
   import pa_core_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [XLEN-1:0]   boot_addr,
   output logic              icache_req_valid_miss,
   output memory_request_t   icache_req_info_miss,
   output logic              dcache_req_valid_miss,
   output memory_request_t   dcache_req_info_miss,
   input  logic              rsp_valid_miss,
   input  logic [LINE_W-1:0] rsp_data_miss,
   input  logic              rsp_cache_id,
   input  logic              rsp_bus_error
);

   state_e            r_state;
   state_e            w_nstate;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_ir;
   logic [XLEN-1:0]   r_regs [32];
   logic              r_ib_v;
   logic [27:0]       r_ib_tag;
   logic [LINE_W-1:0] r_ib_data;
   logic              r_db_v;
   logic [27:0]       r_db_tag;
   logic [LINE_W-1:0] r_db_data;
   logic [27:0]       r_dline;
   logic [1:0]        r_dword;
   logic              r_st_pend;
   logic              r_ireq_v;
   logic              r_dreq_v;
   memory_request_t   r_ireq;
   memory_request_t   r_dreq;

   logic [6:0]        w_op;
   logic [4:0]        w_rd;
   logic [4:0]        w_ra;
   logic [4:0]        w_rb;
   logic [XLEN-1:0]   w_imm;
   logic [XLEN-1:0]   w_va;
   logic [XLEN-1:0]   w_vb;
   logic [XLEN-1:0]   w_vrd;
   logic [XLEN-1:0]   w_alu_b;
   logic [XLEN-1:0]   w_alu_res;
   logic              w_eq;
   logic              w_is_alu;
   logic              w_is_ldw;
   logic              w_is_stw;
   logic              w_is_beq;
   logic              w_is_jmp;
   logic              w_ihit;
   logic              w_dhit;
   logic              w_rsp_ok;
   logic              w_iresp;
   logic              w_dresp;
   logic              w_ireq;
   logic              w_dreq;
   memory_request_t   w_dinfo;
   logic              w_ir_we;
   logic              w_ib_fill;
   logic              w_db_we;
   logic [27:0]       w_db_tag;
   logic [LINE_W-1:0] w_db_line;
   logic              w_rf_we;
   logic [XLEN-1:0]   w_rf_wd;
   logic              w_pc_we;
   logic [XLEN-1:0]   w_pc_nx;
   logic              w_daddr_we;

   assign w_op  = r_ir[31:25];
   assign w_rd  = r_ir[24:20];
   assign w_ra  = r_ir[19:15];
   assign w_rb  = r_ir[14:10];
   assign w_imm = sext15(r_ir[14:0]);
   assign w_va  = r_regs[w_ra];
   assign w_vb  = r_regs[w_rb];
   assign w_vrd = r_regs[w_rd];

   assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                     (w_op == OP_MUL) || (w_op == OP_ADDI);
   assign w_is_ldw = (w_op == OP_LDW);
   assign w_is_stw = (w_op == OP_STW);
   assign w_is_beq = (w_op == OP_BEQ);
   assign w_is_jmp = (w_op == OP_JUMP);

   assign w_alu_b = w_is_beq ? w_vrd : w_vb;

   pa_core_alu u_alu (
      .i_op  (w_op),
      .i_a   (w_va),
      .i_b   (w_alu_b),
      .i_imm (w_imm),
      .o_res (w_alu_res),
      .o_eq  (w_eq)
   );

   assign w_ihit = r_ib_v && (r_ib_tag == r_pc[31:4]);
   assign w_dhit = r_db_v && (r_db_tag == w_alu_res[31:4]);

   // a response coinciding with our own request pulse is not ours
   assign w_rsp_ok = rsp_valid_miss && !r_ireq_v && !r_dreq_v;
   assign w_iresp  = w_rsp_ok && !rsp_cache_id;
   assign w_dresp  = w_rsp_ok &&  rsp_cache_id;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_FETCH;
      else        r_state <= w_nstate;
   end

   always_comb begin
      w_nstate   = r_state;
      w_ireq     = 1'b0;
      w_dreq     = 1'b0;
      w_dinfo    = '0;
      w_ir_we    = 1'b0;
      w_ib_fill  = 1'b0;
      w_db_we    = 1'b0;
      w_db_tag   = w_alu_res[31:4];
      w_db_line  = r_db_data;
      w_rf_we    = 1'b0;
      w_rf_wd    = w_alu_res;
      w_pc_we    = 1'b0;
      w_pc_nx    = r_pc + 32'd4;
      w_daddr_we = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (w_ihit) begin
               w_ir_we  = 1'b1;
               w_nstate = ST_EXEC;
            end else begin
               w_ireq   = 1'b1;
               w_nstate = ST_IWAIT;
            end
         end
         ST_IWAIT: begin
            if (w_iresp) begin
               w_ib_fill = !rsp_bus_error;
               w_nstate  = rsp_bus_error ? ST_HALT : ST_FETCH;
            end
         end
         ST_EXEC: begin
            w_nstate = ST_FETCH;
            w_pc_we  = 1'b1;
            unique case (1'b1)
               w_is_alu: w_rf_we = 1'b1;
               w_is_beq: begin
                  if (w_eq) w_pc_nx = r_pc + w_imm;
               end
               w_is_jmp: w_pc_nx = w_va;
               w_is_ldw: begin
                  if (w_dhit) begin
                     w_rf_we = 1'b1;
                     w_rf_wd = get_word(r_db_data,
                                        w_alu_res[3:2]);
                  end else begin
                     w_pc_we       = 1'b0;
                     w_dreq        = 1'b1;
                     w_dinfo.addr  = {4'd0, w_alu_res[31:4]};
                     w_daddr_we    = 1'b1;
                     w_nstate      = ST_DWAIT;
                  end
               end
               w_is_stw: begin
                  w_pc_we      = 1'b0;
                  w_dreq       = 1'b1;
                  w_dinfo.addr = {4'd0, w_alu_res[31:4]};
                  w_daddr_we   = 1'b1;
                  if (w_dhit) begin
                     w_db_we   = 1'b1;
                     w_db_line = put_word(r_db_data,
                                          w_alu_res[3:2], w_vrd);
                     w_dinfo.is_store = 1'b1;
                     w_dinfo.data     = w_db_line;
                     w_nstate  = ST_SWAIT;
                  end else begin
                     w_nstate  = ST_DWAIT;
                  end
               end
               default: ;
            endcase
         end
         ST_DWAIT: begin
            if (w_dresp && rsp_bus_error) begin
               w_nstate = ST_HALT;
            end else if (w_dresp) begin
               w_db_we  = 1'b1;
               w_db_tag = r_dline;
               if (r_st_pend) begin
                  w_db_line = put_word(rsp_data_miss,
                                       r_dword, w_vrd);
                  w_dreq           = 1'b1;
                  w_dinfo.addr     = {4'd0, r_dline};
                  w_dinfo.is_store = 1'b1;
                  w_dinfo.data     = w_db_line;
                  w_nstate         = ST_SWAIT;
               end else begin
                  w_db_line = rsp_data_miss;
                  w_rf_we   = 1'b1;
                  w_rf_wd   = get_word(rsp_data_miss, r_dword);
                  w_pc_we   = 1'b1;
                  w_nstate  = ST_FETCH;
               end
            end
         end
         ST_SWAIT: begin
            if (w_dresp) begin
               w_pc_we  = !rsp_bus_error;
               w_nstate = rsp_bus_error ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: ;
         default: w_nstate = ST_HALT;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pc      <= boot_addr;
         r_ir      <= '0;
         r_ib_v    <= 1'b0;
         r_ib_tag  <= '0;
         r_ib_data <= '0;
         r_db_v    <= 1'b0;
         r_db_tag  <= '0;
         r_db_data <= '0;
         r_dline   <= '0;
         r_dword   <= '0;
         r_st_pend <= 1'b0;
         r_ireq_v  <= 1'b0;
         r_ireq    <= '0;
         r_dreq_v  <= 1'b0;
         r_dreq    <= '0;
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else begin
         r_ireq_v      <= w_ireq;
         r_ireq        <= '0;
         if (w_ireq) r_ireq.addr <= {4'd0, r_pc[31:4]};
         r_dreq_v      <= w_dreq;
         r_dreq        <= w_dinfo;
         if (w_ir_we) r_ir <= get_word(r_ib_data, r_pc[3:2]);
         if (w_ib_fill) begin
            r_ib_v    <= 1'b1;
            r_ib_tag  <= r_pc[31:4];
            r_ib_data <= rsp_data_miss;
         end
         if (w_db_we) begin
            r_db_v    <= 1'b1;
            r_db_tag  <= w_db_tag;
            r_db_data <= w_db_line;
         end
         if (w_daddr_we) begin
            r_dline   <= w_alu_res[31:4];
            r_dword   <= w_alu_res[3:2];
            r_st_pend <= w_is_stw;
         end
         if (w_rf_we) r_regs[w_rd] <= w_rf_wd;
         if (w_pc_we) r_pc <= w_pc_nx;
      end
   end

   assign icache_req_valid_miss = r_ireq_v;
   assign icache_req_info_miss  = r_ireq;
   assign dcache_req_valid_miss = r_dreq_v;
   assign dcache_req_info_miss  = r_dreq;

endmodule

// File: tb/tb_pa_core_top.sv
// tb_pa_core_top: memory model plus request scoreboard for
// the pa_core multicycle core.
module tb_pa_core_top;
   import pa_core_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       boot = 32'h1000;
   logic              iv, dv;
   memory_request_t   ii, di;
   logic              rsp_v = 1'b0;
   logic [LINE_W-1:0] rsp_d = '0;
   logic              rsp_id = 1'b0;
   logic              rsp_err = 1'b0;

   always #5 clk = ~clk;

   pa_core_top dut (
      .clock                 (clk),
      .reset                 (rst_n),
      .boot_addr             (boot),
      .icache_req_valid_miss (iv),
      .icache_req_info_miss  (ii),
      .dcache_req_valid_miss (dv),
      .dcache_req_info_miss  (di),
      .rsp_valid_miss        (rsp_v),
      .rsp_data_miss         (rsp_d),
      .rsp_cache_id          (rsp_id),
      .rsp_bus_error         (rsp_err)
   );

   typedef struct packed {
      logic              side;
      logic [31:0]       addr;
      logic              st;
      logic [LINE_W-1:0] data;
   } req_t;

   typedef struct {
      logic [6:0]  op;
      logic [14:0] a;
      logic [14:0] b;
      logic [14:0] c;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 11;
   localparam logic [14:0] RB2 = 15'h0800;

   req_t              exp_q[$];
   logic [LINE_W-1:0] mem [logic [31:0]];
   int                n_chk = 0;
   int                n_fail = 0;
   int                n_pulse = 0;
   bit                dup_mode, stray_mode, err_en;
   logic [31:0]       err_line;
   int                lat = 2;
   logic [LINE_W-1:0] bogus;
   logic [LINE_W-1:0] data0;
   logic [31:0]       loop_w;
   req_t              m_act, m_exp;
   memory_request_t   r_info;
   logic              r_side, r_err;
   vec_t              vt [NV];

   function automatic logic [31:0] enc(
      input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] ra, input logic [14:0] imm);
      return {op, rd, ra, imm};
   endfunction

   function automatic logic [LINE_W-1:0] ln4(
      input logic [31:0] w0, input logic [31:0] w1,
      input logic [31:0] w2, input logic [31:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   function automatic logic [LINE_W-1:0] mem_rd(
      input logic [31:0] a);
      return mem.exists(a) ? mem[a] : '0;
   endfunction

   function automatic void pushx(input logic side,
      input logic [31:0] addr, input logic st,
      input logic [LINE_W-1:0] data);
      exp_q.push_back({side, addr, st, data});
   endfunction

   task automatic cfg(input bit dup, input bit stray,
                      input bit ee, input logic [31:0] el,
                      input int l);
      dup_mode   = dup;
      stray_mode = stray;
      err_en     = ee;
      err_line   = el;
      lat        = l;
      mem.delete();
   endtask

   task automatic drive(input logic id,
                        input logic [LINE_W-1:0] d,
                        input logic e);
      rsp_v   = 1'b1;
      rsp_id  = id;
      rsp_d   = d;
      rsp_err = e;
   endtask

   task automatic idle();
      rsp_v   = 1'b0;
      rsp_d   = '0;
      rsp_err = 1'b0;
   endtask

   // scoreboard: every pulse must match the next expected request
   always @(negedge clk) begin
      if (rst_n && (iv || dv)) begin
         n_pulse++;
         n_chk++;
         m_act.side = dv;
         m_act.addr = dv ? di.addr : ii.addr;
         m_act.st   = dv ? di.is_store : ii.is_store;
         m_act.data = dv ? di.data : ii.data;
         if (iv && dv) begin
            n_fail++;
            $display("FAIL dual_pulse got iv=1 dv=1 exp one");
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_req got side=%0d addr=%h st=%0d exp none",
                     m_act.side, m_act.addr, m_act.st);
         end else begin
            m_exp = exp_q.pop_front();
            if (m_act !== m_exp) begin
               n_fail++;
               $display("FAIL req got side=%0d addr=%h st=%0d data=%h exp side=%0d addr=%h st=%0d data=%h",
                        m_act.side, m_act.addr, m_act.st, m_act.data,
                        m_exp.side, m_exp.addr, m_exp.st, m_exp.data);
            end
         end
      end
   end

   // memory responder
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && (iv || dv)) begin
            r_side = dv;
            r_info = dv ? di : ii;
            if (dup_mode) drive(r_side, bogus, 1'b0);
            @(posedge clk);
            #1 idle();
            repeat (lat) @(posedge clk);
            #1;
            if (stray_mode) begin
               drive(!r_side, bogus, 1'b0);
               @(posedge clk);
               #1 idle();
            end
            r_err = err_en && (r_info.addr == err_line);
            if (r_info.is_store && !r_err)
               mem[r_info.addr] = r_info.data;
            drive(r_side,
                  r_info.is_store ? bogus : mem_rd(r_info.addr),
                  r_err);
            @(posedge clk);
            #1 idle();
         end
      end
   end

   task automatic run(input int drain);
      int n_exp;
      n_exp   = exp_q.size();
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (iv !== 1'b0 || dv !== 1'b0 || ii !== '0 || di !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got iv=%0d dv=%0d exp 0 0",
                  iv, dv);
      end
      n_pulse = 0;
      rst_n   = 1'b1;
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++)
         @(posedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL timeout got pending=%0d exp 0", exp_q.size());
         exp_q.delete();
      end
      repeat (drain) @(posedge clk);
      n_chk++;
      if (n_pulse != n_exp) begin
         n_fail++;
         $display("FAIL pulse_count got %0d exp %0d", n_pulse, n_exp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got running exp finished");
      $fatal(1);
   end

   initial begin
      bogus  = {4{enc(OP_STW, 5'd0, 5'd0, 15'h3000)}};
      loop_w = enc(OP_BEQ, 5'd0, 5'd0, 15'd0);
      data0  = ln4(32'hAAAA0000, 32'hBBBB0001,
                   32'hCCCC0002, 32'hDDDD0003);

      vt[0]  = '{OP_ADD,  15'd5,     15'd7,     RB2,      32'd12};
      vt[1]  = '{OP_MUL,  15'd12,    15'd12,    RB2,      32'd144};
      vt[2]  = '{OP_SUB,  15'd3,     15'd10,    RB2,      32'hFFFFFFF9};
      vt[3]  = '{OP_MUL,  15'h3FFF,  15'h3FFF,  RB2,      32'h0FFF8001};
      vt[4]  = '{OP_MUL,  15'h7FFE,  15'h3FFF,  RB2,      32'hFFFF8002};
      vt[5]  = '{OP_ADD,  15'h7FFF,  15'd1,     RB2,      32'd0};
      vt[6]  = '{OP_ADDI, 15'd100,   15'd0,     15'h4000, 32'hFFFFC064};
      vt[7]  = '{OP_SUB,  15'd0,     15'h4000,  RB2,      32'h00004000};
      vt[8]  = '{OP_NOP,  15'd1,     15'd2,     15'h7FFF, 32'd0};
      vt[9]  = '{7'h03,   15'd1,     15'd2,     RB2,      32'd0};
      vt[10] = '{7'h40,   15'd1,     15'd2,     RB2,      32'd0};

      for (int k = 0; k < NV; k++) begin
         cfg(1'b0, 1'b0, 1'b0, 32'h0, 2);
         mem[32'h100] = ln4(enc(OP_ADDI, 5'd1, 5'd0, vt[k].a),
                            enc(OP_ADDI, 5'd2, 5'd0, vt[k].b),
                            enc(vt[k].op, 5'd3, 5'd1, vt[k].c),
                            enc(OP_STW, 5'd3, 5'd0, 15'h2004));
         mem[32'h101] = ln4(loop_w, 32'h0, 32'h0, 32'h0);
         mem[32'h200] = data0;
         pushx(1'b0, 32'h100, 1'b0, '0);
         pushx(1'b1, 32'h200, 1'b0, '0);
         pushx(1'b1, 32'h200, 1'b1,
               ln4(32'hAAAA0000, vt[k].exp,
                   32'hCCCC0002, 32'hDDDD0003));
         pushx(1'b0, 32'h101, 1'b0, '0);
         run(30);
      end

      // store miss, store hit, load hit; then with stray/early rsp
      for (int m = 0; m < 2; m++) begin
         cfg(m == 1, m == 1, 1'b0, 32'h0, (m == 1) ? 0 : 3);
         mem[32'h100] = ln4(enc(OP_ADDI, 5'd3, 5'd0, 15'd12),
                            enc(OP_STW, 5'd3, 5'd0, 15'h2004),
                            enc(OP_LDW, 5'd5, 5'd0, 15'h2004),
                            enc(OP_STW, 5'd5, 5'd0, 15'h2008));
         mem[32'h101] = ln4(loop_w, 32'h0, 32'h0, 32'h0);
         mem[32'h200] = data0;
         pushx(1'b0, 32'h100, 1'b0, '0);
         pushx(1'b1, 32'h200, 1'b0, '0);
         pushx(1'b1, 32'h200, 1'b1,
               ln4(32'hAAAA0000, 32'd12, 32'hCCCC0002, 32'hDDDD0003));
         pushx(1'b1, 32'h200, 1'b1,
               ln4(32'hAAAA0000, 32'd12, 32'd12, 32'hDDDD0003));
         pushx(1'b0, 32'h101, 1'b0, '0);
         run(40);
      end

      // load miss, then store miss to another line
      cfg(1'b0, 1'b0, 1'b0, 32'h0, 1);
      mem[32'h100] = ln4(enc(OP_LDW, 5'd6, 5'd0, 15'h2008),
                         enc(OP_ADDI, 5'd7, 5'd6, 15'd1),
                         enc(OP_STW, 5'd7, 5'd0, 15'h2030),
                         loop_w);
      mem[32'h200] = data0;
      pushx(1'b0, 32'h100, 1'b0, '0);
      pushx(1'b1, 32'h200, 1'b0, '0);
      pushx(1'b1, 32'h203, 1'b0, '0);
      pushx(1'b1, 32'h203, 1'b1,
            ln4(32'hCCCC0003, 32'h0, 32'h0, 32'h0));
      run(30);

      // taken BEQ, not-taken BEQ, JUMP through r2=0
      cfg(1'b0, 1'b0, 1'b0, 32'h0, 2);
      mem[32'h100] = ln4(enc(OP_BEQ, 5'd1, 5'd1, 15'h0010),
                         enc(OP_STW, 5'd0, 5'd0, 15'h2000),
                         32'h0, 32'h0);
      mem[32'h101] = ln4(enc(OP_ADDI, 5'd1, 5'd0, 15'd1),
                         enc(OP_BEQ, 5'd1, 5'd0, 15'h0040),
                         enc(OP_JUMP, 5'd0, 5'd2, 15'd0),
                         enc(OP_STW, 5'd0, 5'd0, 15'h2000));
      mem[32'h000] = ln4(loop_w, 32'h0, 32'h0, 32'h0);
      pushx(1'b0, 32'h100, 1'b0, '0);
      pushx(1'b0, 32'h101, 1'b0, '0);
      pushx(1'b0, 32'h000, 1'b0, '0);
      run(30);

      // I-side bus error halts the core
      cfg(1'b0, 1'b0, 1'b1, 32'h100, 2);
      mem[32'h100] = ln4(loop_w, 32'h0, 32'h0, 32'h0);
      pushx(1'b0, 32'h100, 1'b0, '0);
      run(100);

      // D-side bus error on a load halts the core
      cfg(1'b0, 1'b0, 1'b1, 32'h200, 2);
      mem[32'h100] = ln4(enc(OP_LDW, 5'd1, 5'd0, 15'h2000),
                         enc(OP_STW, 5'd0, 5'd0, 15'h3000),
                         32'h0, 32'h0);
      pushx(1'b0, 32'h100, 1'b0, '0);
      pushx(1'b1, 32'h200, 1'b0, '0);
      run(100);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pa_core_top.md
# pa_core_top

Minimal multicycle in-order processor core with a one-line instruction buffer and a one-line write-through data buffer. It is the top of the core and talks to the memory hierarchy through two single-pulse miss-request ports (I-side, D-side) and one shared response port. All memory traffic is whole 128-bit lines addressed by line index.

## Interface
- LINE_W, 128, line width in bits; each line holds 4 instructions or data words.
- XLEN, 32, register, instruction and byte-address width.
- memory_request_t (package type), fields: addr[31:0] (line index = byte address >> 4), is_store (1 bit), data[LINE_W-1:0].
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; state is cleared while low.
- boot_addr  in  32  byte address of the first instruction; sampled on reset release.
- icache_req_valid_miss  out  1  one-cycle pulse requesting an instruction line.
- icache_req_info_miss  out  memory_request_t  is_store=0; valid only in the pulse cycle.
- dcache_req_valid_miss  out  1  one-cycle pulse requesting a data load or store.
- dcache_req_info_miss  out  memory_request_t  load or store descriptor; valid only in the pulse cycle.
- rsp_valid_miss  in  1  one-cycle response pulse.
- rsp_data_miss  in  LINE_W  returned line; ignored for store acknowledgements.
- rsp_cache_id  in  1  0 = I-side, 1 = D-side.
- rsp_bus_error  in  1  request address out of range.

## Operation
- 32 general registers r0..r31, 32-bit, reset to 0. r0 is writable.
- Instruction format: op[31:25], rd[24:20], ra[19:15], rb[14:10], imm[14:0] (signed).
  - 0x00 ADD rd=ra+rb.
  - 0x01 SUB rd=ra-rb.
  - 0x02 MUL rd=low32(ra*rb).
  - 0x05 ADDI rd=ra+sext(imm).
  - 0x11 LDW rd=mem32[ra+sext(imm)].
  - 0x13 STW mem32[ra+sext(imm)]=rd.
  - 0x30 BEQ: if rd==ra, pc=pc+sext(imm).
  - 0x31 JUMP pc=ra.
  - 0x7F (includes all-ones) NOP.
  - Any other op: NOP.
- Arithmetic wraps modulo 2^32. Data addresses are word-aligned; bits[1:0] are ignored. The word within a line is selected by address bits [3:2]; word 0 is line bits [31:0].
- Instruction buffer (valid, line tag, line data):
  - On a tag mismatch, pulse icache_req_valid_miss with addr = pc>>4.
  - Wait for a response with cache_id=0, then fill the buffer.
- Data buffer, same layout:
  - LDW hit: read the buffered word. LDW miss: pulse a D-side load, wait for cache_id=1, fill the buffer, write rd.
  - STW miss: first load the line as above. Then merge the word into the buffer and pulse a D-side store (is_store=1, data = merged line). Wait for the cache_id=1 acknowledgement.
- Only one request is outstanding at a time. Responses carrying the non-awaited cache_id are ignored.
- rsp_bus_error on any awaited response: enter HALT. In HALT no further requests are issued until reset.
- Non-branch instructions advance pc by 4.

## Timing
- Reset values: all outputs 0, both buffers invalid, pc=boot_addr, state FETCH.
- FSM transitions:
  - FETCH: on hit go to EXEC; on miss pulse the request and go to IWAIT.
  - IWAIT: on the response go to FETCH (the refetch hits).
  - EXEC: ALU ops, branches and buffer-hit loads complete in 1 cycle and return to FETCH. Data misses go to DWAIT. Stores go to SWAIT.
  - DWAIT: on the response complete the load, or for a store go to SWAIT.
  - SWAIT: on the acknowledgement go to FETCH.
  - HALT: terminal.
- A request pulse is asserted for exactly one cycle, in the cycle the FSM enters a wait state.
- A response in the same cycle as a request pulse is not accepted.
- An ALU instruction that hits takes 2 cycles (FETCH + EXEC).
- A reset assertion mid-wait aborts the transaction; late responses after reset release are ignored, because no wait state is active.

## Structure
- The shared package holds memory_request_t, the LINE_W/XLEN constants, the opcode localparams and the FSM state enum.
- One sub-module, pa_core_alu: combinational ADD/SUB/MUL/ADDI and the BEQ compare.
- The register file, both buffers and the FSM live in pa_core_top.

## Test plan
- Boot: release reset with boot_addr=0x1000 -> one I-pulse with addr=0x100 and is_store=0; no D-pulse.
- ALU: line words = ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; MUL r4,r3,r3 -> r3=12, r4=144; only one I-request for the whole line.
- Load/store: STW r3 to byte 0x2004 -> D load with addr=0x200, then D store with data word1=12 and the other words unchanged. A following LDW r5 from 0x2004 hits the buffer and issues no request; r5=12.
- Branch: BEQ r1,r1,+0x10 at 0x1000 -> next fetch is 0x1010, an I-request for line 0x101.
- Error: respond to the I-request with rsp_bus_error=1 -> core halts; no further pulses over 100 cycles.
- Stray response: a cache_id=1 pulse while in IWAIT -> ignored; state and registers unchanged.
